mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs (ALU result as address, forwarded rs2 as store data, control bits) and drives the data-memory request/ready bus with byte lanes aligned. It holds the pipeline while a multi-cycle access is outstanding, extracts and extends load data, and owns the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT, 16, max cycles an access may wait for dmem_ready before faulting (≥2)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- pc_plus4  in  32  EX/MEM link address
- alu_result  in  32  effective address / ALU value
- rs2_data  in  32  store data (already forwarded)
- rd_addr  in  5  destination register
- mem_read, mem_write, mem_to_reg, reg_write  in  1 each  EX/MEM control
- jump  in  1  write pc_plus4 as result (JAL/JALR)
- mem_funct3  in  3  load/store width/sign (RV32I funct3)
- dmem_req  out  1  access request, held until ready
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read word, valid when dmem_ready
- dmem_ready  in  1  access completes at this posedge
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- forward_mem_data  out  32  combinational forward to EX (pc_plus4 if jump else alu_result)
- wb_data_out  out  32  MEM/WB result
- rd_addr_out  out  5  MEM/WB destination
- reg_write_out  out  1  MEM/WB write enable
- exc_valid_out  out  1  MEM/WB exception flag
- exc_cause_out  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault

## Operation
- access = mem_read | mem_write; misaligned = (halfword & addr[0]) | (word & addr[1:0]≠0).
- Misaligned: no request, no stall; MEM/WB gets reg_write_out=0, exc_valid_out=1, cause 4/6.
- Store byte lanes: SB be=1<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111.
- Load: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Loads drive be=1111.
- wb_data: load data if mem_to_reg, else pc_plus4 if jump, else alu_result.
- FSM IDLE/WAIT, wait counter cnt (clog2(TIMEOUT) bits):
  - IDLE: aligned access & !dmem_ready → WAIT, cnt←1. Aligned access & dmem_ready → stay IDLE (zero-wait).
  - WAIT: dmem_ready → IDLE, cnt←0. Else cnt==TIMEOUT-1 → IDLE, fault; else cnt++.
- dmem_req = aligned access & !timeout_hit (timeout_hit = WAIT & cnt==TIMEOUT-1 & !dmem_ready).
- mem_stall = dmem_req & !dmem_ready.
- Timeout: stall drops, MEM/WB gets reg_write_out=0, exc_valid_out=1, cause 5/7.
- dmem_addr/we/wdata/be are functions of held EX/MEM inputs, hence stable while stalled.

## Timing
- Reset: state IDLE, cnt 0, wb_data_out 0, rd_addr_out 0, reg_write_out 0, exc_valid_out 0, exc_cause_out 0. Combinational outputs follow inputs; dmem_req is 0 when EX/MEM is reset.
- MEM/WB updates every posedge. When mem_stall=1 it loads a bubble (reg_write_out=0, exc_valid_out=0) so WB never writes twice.
- Zero-wait access: one cycle, no stall. N-wait access: N stall cycles; the result is in MEM/WB on the posedge where dmem_ready=1.
- dmem_ready while dmem_req=0 is ignored.
- Ready on the timeout cycle wins: completes normally, no fault.
- Reset mid-WAIT: returns to IDLE and drops the request. The memory side must tolerate an abandoned request.

## Structure
- defines.vh: funct3 load/store codes (LB, LH, LW, LBU, LHU, SB, SH, SW), exception cause codes 4–7, FSM state encodings.
- Sub-module lsu_align: combinational byte-lane logic (be, wdata replication, load extract/extend, misalign detect). FSM and MEM/WB register stay in mem_stage.

## Test plan
- SW 0xDEADBEEF @0x100, ready same cycle → be=1111, wdata=0xDEADBEEF, mem_stall never 1, reg_write_out=0.
- LB @0x103, rdata 0x80FF_0000, ready after 3 cycles → mem_stall high 3 cycles, then wb_data_out=0xFFFFFF80, reg_write_out=1, one bubble per stall cycle.
- LHU @0x102, rdata 0xBEEF_1234, zero-wait → wb_data_out=0x0000BEEF. SH @0x102 with rs2=0x1234 → be=1100, wdata=0x12341234.
- LW @0x101 → dmem_req=0, no stall, exc_valid_out=1, cause 4, reg_write_out=0.
- SB with dmem_ready held low and TIMEOUT=16 → stall exactly 15 cycles, then cause 7, state IDLE. Repeat with ready asserted on cycle 15 → normal completion, no fault.
- Assert rst_n low during WAIT → all registered outputs 0, state IDLE. The next zero-wait LW completes in one cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store funct3 codes,
// memory exception causes and the access FSM states.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic [3:0] exc_cause(input logic is_load, input logic is_fault);
        if (is_load) begin
            return is_fault ? CAUSE_LOAD_FAULT : CAUSE_LOAD_MISALIGNED;
        end
        return is_fault ? CAUSE_STORE_FAULT : CAUSE_STORE_MISALIGNED;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store enables and lane replication,
// load byte/half extraction with sign/zero extension, misalignment detect.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_misaligned = 1'b0;
        if (i_funct3[1:0] == F3_LH[1:0]) begin
            o_misaligned = i_addr_lo[0];
        end else if (i_funct3[1:0] == F3_LW[1:0]) begin
            o_misaligned = |i_addr_lo;
        end
    end

    always_comb begin
        o_be    = '1;
        o_wdata = i_store_data;
        if (i_is_store) begin
            case (i_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                F3_SH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                F3_SW: begin
                    o_be    = '1;
                    o_wdata = i_store_data;
                end
                default: begin
                    o_be    = '1;
                    o_wdata = i_store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_load_data = {24'h0, w_byte};
            F3_LHU:  o_load_data = {16'h0, w_half};
            default: o_load_data = i_load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: data-memory request/ready handshake with
// wait-timeout fault, pipeline stall generation and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic        jump,
    input  logic [2:0]  mem_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic [31:0] forward_mem_data,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_addr_out,
    output logic        reg_write_out,
    output logic        exc_valid_out,
    output logic [3:0]  exc_cause_out
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic        w_access;
    logic        w_misaligned;
    logic        w_aligned_access;
    logic        w_timeout_hit;
    logic [31:0] w_load_data;
    logic [31:0] w_result;

    logic [31:0] r_wb_data;
    logic [4:0]  r_rd_addr;
    logic        r_reg_write;
    logic        r_exc_valid;
    logic [3:0]  r_exc_cause;

    lsu_align u_align (
        .i_addr_lo    (alu_result[1:0]),
        .i_funct3     (mem_funct3),
        .i_is_store   (mem_write),
        .i_store_data (rs2_data),
        .i_load_word  (dmem_rdata),
        .o_be         (dmem_be),
        .o_wdata      (dmem_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    assign w_access         = mem_read | mem_write;
    assign w_aligned_access = w_access & ~w_misaligned;
    assign w_timeout_hit    = (r_state == ST_WAIT) && (r_cnt == CNT_LAST) && !dmem_ready;

    assign dmem_req  = w_aligned_access & ~w_timeout_hit;
    assign dmem_we   = mem_write;
    assign dmem_addr = {alu_result[31:2], 2'b00};
    assign mem_stall = dmem_req & ~dmem_ready;

    assign forward_mem_data = jump ? pc_plus4 : alu_result;
    assign w_result         = mem_to_reg ? w_load_data : forward_mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A ready on the last wait cycle completes the access; only a silent
    // memory on that cycle produces the fault.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_aligned_access && !dmem_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!w_aligned_access || dmem_ready || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data   <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
        end else begin
            r_wb_data <= w_result;
            r_rd_addr <= rd_addr;
            if (mem_stall) begin
                r_reg_write <= 1'b0;
                r_exc_valid <= 1'b0;
                r_exc_cause <= '0;
            end else if (w_access && w_misaligned) begin
                r_reg_write <= 1'b0;
                r_exc_valid <= 1'b1;
                r_exc_cause <= exc_cause(mem_read, 1'b0);
            end else if (w_timeout_hit) begin
                r_reg_write <= 1'b0;
                r_exc_valid <= 1'b1;
                r_exc_cause <= exc_cause(mem_read, 1'b1);
            end else begin
                r_reg_write <= reg_write;
                r_exc_valid <= 1'b0;
                r_exc_cause <= '0;
            end
        end
    end

    assign wb_data_out   = r_wb_data;
    assign rd_addr_out   = r_rd_addr;
    assign reg_write_out = r_reg_write;
    assign exc_valid_out = r_exc_valid;
    assign exc_cause_out = r_exc_cause;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues EX/MEM instructions and
// memory responses, a monitor checks bus, stall and MEM/WB against a model.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int unsigned TMO   = 16;
    localparam int unsigned NEVER = 99;

    typedef struct {
        bit          rd_;
        bit          wr;
        bit          m2r;
        bit          rw;
        bit          jmp;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int unsigned wait_n;
        int unsigned cycles;
        int unsigned stall_n;
        bit          exp_req;
        bit          tmo;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          e_rw;
        bit          e_exc;
        logic [3:0]  e_cause;
        logic [31:0] e_wb;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_plus4 = '0, alu_result = '0, rs2_data = '0, dmem_rdata = '0;
    logic [4:0]  rd_addr = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic        reg_write = 1'b0, jump = 1'b0, dmem_ready = 1'b0;
    logic [2:0]  mem_funct3 = '0;
    logic        dmem_req, dmem_we, mem_stall, reg_write_out, exc_valid_out;
    logic [31:0] dmem_addr, dmem_wdata, forward_mem_data, wb_data_out;
    logic [3:0]  dmem_be, exc_cause_out;
    logic [4:0]  rd_addr_out;

    bit   tb_valid = 1'b0;
    txn_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pc_plus4(pc_plus4), .alu_result(alu_result),
        .rs2_data(rs2_data), .rd_addr(rd_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .jump(jump), .mem_funct3(mem_funct3), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
        .forward_mem_data(forward_mem_data), .wb_data_out(wb_data_out),
        .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
        .exc_valid_out(exc_valid_out), .exc_cause_out(exc_cause_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size from funct3, alignment by modulo,
    // lanes by shifting, extension by arithmetic.
    function automatic txn_t model(input txn_t t);
        int unsigned size;
        bit          access, mis;
        logic [31:0] lane, ld;
        size   = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
        access = t.rd_ || t.wr;
        mis    = access && ((t.addr % size) != 0);
        t.exp_req = access && !mis;
        t.tmo     = t.exp_req && (t.wait_n > TMO - 1);
        t.stall_n = !t.exp_req ? 0 : ((t.wait_n < TMO - 1) ? t.wait_n : TMO - 1);
        t.cycles  = t.stall_n + 1;
        if (t.wr) begin
            t.be    = 4'(((1 << size) - 1) << (t.addr % 4));
            t.wdata = (size == 1) ? t.rs2[7:0] * 32'h0101_0101 :
                      (size == 2) ? t.rs2[15:0] * 32'h0001_0001 : t.rs2;
        end else begin
            t.be    = 4'hF;
            t.wdata = '0;
        end
        lane = t.rdata >> (8 * (t.addr % 4));
        if (size == 1) begin
            ld = {24'h0, lane[7:0]};
            if (!t.f3[2] && ld >= 32'd128) ld = ld - 32'd256;
        end else if (size == 2) begin
            ld = {16'h0, lane[15:0]};
            if (!t.f3[2] && ld >= 32'd32768) ld = ld - 32'd65536;
        end else begin
            ld = t.rdata;
        end
        if (mis) begin
            t.e_rw = 0; t.e_exc = 1; t.e_cause = t.rd_ ? 4'd4 : 4'd6;
        end else if (t.tmo) begin
            t.e_rw = 0; t.e_exc = 1; t.e_cause = t.rd_ ? 4'd5 : 4'd7;
        end else begin
            t.e_rw = t.rw; t.e_exc = 0; t.e_cause = 4'd0;
        end
        t.e_wb = t.m2r ? ld : (t.jmp ? t.pc4 : t.addr);
        return t;
    endfunction

    function automatic txn_t mk(input bit rd_, input bit wr, input bit jmp, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input int unsigned wait_n);
        txn_t t;
        t.rd_ = rd_; t.wr = wr; t.jmp = jmp; t.f3 = f3;
        t.m2r = rd_; t.rw = !wr;
        t.addr = addr; t.rs2 = rs2; t.rdata = rdata; t.wait_n = wait_n;
        t.pc4 = $urandom; t.rd = 5'($urandom_range(1, 31));
        return t;
    endfunction

    task automatic drive_inputs(input txn_t t);
        pc_plus4 = t.pc4; alu_result = t.addr; rs2_data = t.rs2; rd_addr = t.rd;
        mem_read = t.rd_; mem_write = t.wr; mem_to_reg = t.m2r; reg_write = t.rw;
        jump = t.jmp; mem_funct3 = t.f3; dmem_rdata = t.rdata;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0; jump = 0;
        dmem_ready = 0; tb_valid = 0;
    endtask

    // Entered and left at posedge+1; holds the instruction for the model's cycle count.
    task automatic run_txn(input txn_t t);
        t = model(t);
        sbq.push_back(t);
        drive_inputs(t);
        tb_valid = 1;
        for (int unsigned k = 0; k < t.cycles; k++) begin
            dmem_ready = (k == t.wait_n);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin : monitor
        txn_t t;
        int unsigned k;
        bit exp_req_now;
        k = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tb_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL scoreboard: got empty queue required pending instruction");
                end else begin
                    t = sbq[0];
                    exp_req_now = t.exp_req && !(t.tmo && k == TMO - 1);
                    chk("dmem_req", dmem_req, exp_req_now);
                    chk("mem_stall", mem_stall, k < t.stall_n);
                    chk("forward", forward_mem_data, t.jmp ? t.pc4 : t.addr);
                    if (exp_req_now) begin
                        chk("dmem_addr", dmem_addr, t.addr & 32'hFFFF_FFFC);
                        chk("dmem_we", dmem_we, t.wr);
                        chk("dmem_be", dmem_be, t.be);
                        if (t.wr) chk("dmem_wdata", dmem_wdata, t.wdata);
                    end
                    @(posedge clk); #2;
                    if (k + 1 >= t.cycles) begin
                        t = sbq.pop_front();
                        chk("reg_write_out", reg_write_out, t.e_rw);
                        chk("exc_valid_out", exc_valid_out, t.e_exc);
                        chk("exc_cause_out", exc_cause_out, t.e_cause);
                        if (t.e_rw) begin
                            chk("wb_data_out", wb_data_out, t.e_wb);
                            chk("rd_addr_out", rd_addr_out, t.rd);
                        end
                        k = 0;
                    end else begin
                        chk("bubble_rw", reg_write_out, 0);
                        chk("bubble_exc", exc_valid_out, 0);
                        k++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "bench time limit reached");
    end

    initial begin : driver
        txn_t t;
        int unsigned op, sz;
        logic [2:0] lf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (2) @(posedge clk);
        #2;
        chk("rst_wb_data", wb_data_out, 0);
        chk("rst_rd_addr", rd_addr_out, 0);
        chk("rst_reg_write", reg_write_out, 0);
        chk("rst_exc_valid", exc_valid_out, 0);
        chk("rst_exc_cause", exc_cause_out, 0);
        chk("rst_dmem_req", dmem_req, 0);
        @(posedge clk); #1;
        rst_n = 1;

        run_txn(mk(0, 1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0));
        run_txn(mk(1, 0, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 3));
        run_txn(mk(1, 0, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF_1234, 0));
        run_txn(mk(0, 1, 0, 3'b001, 32'h102, 32'h1234, 32'h0, 0));
        run_txn(mk(1, 0, 0, 3'b010, 32'h101, 32'h0, 32'h1111_2222, 0));
        run_txn(mk(0, 1, 0, 3'b000, 32'h201, 32'hA5, 32'h0, NEVER));
        run_txn(mk(0, 1, 0, 3'b000, 32'h202, 32'h5A, 32'h0, TMO - 1));
        run_txn(mk(1, 0, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, TMO - 1));
        run_txn(mk(0, 0, 1, 3'b000, 32'h444, 32'h0, 32'h0, 0));

        // Abandon an outstanding load by resetting mid-wait.
        t = mk(1, 0, 0, 3'b010, 32'h400, 32'h0, 32'h0, NEVER);
        drive_inputs(t);
        dmem_ready = 0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_wb_data", wb_data_out, 0);
        chk("midrst_rd_addr", rd_addr_out, 0);
        chk("midrst_reg_write", reg_write_out, 0);
        chk("midrst_exc_valid", exc_valid_out, 0);
        clear_inputs();
        #1;
        chk("midrst_dmem_req", dmem_req, 0);
        @(posedge clk); #1;
        rst_n = 1;
        run_txn(mk(1, 0, 0, 3'b010, 32'h500, 32'h0, 32'h1357_9BDF, 0));
        run_txn(mk(1, 0, 0, 3'b100, 32'h501, 32'h0, 32'h0000_9900, NEVER));

        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: sz = 0;
                4, 5, 6, 7: sz = $urandom_range(1, 5);
                8:          sz = $urandom_range(6, TMO);
                default:    sz = NEVER;
            endcase
            if (op <= 3) begin
                t = mk(1, 0, 0, lf3[$urandom_range(0, 4)], $urandom, 0, $urandom, sz);
            end else if (op <= 6) begin
                t = mk(0, 1, 0, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom, sz);
            end else begin
                t = mk(0, 0, op == 8, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 0);
            end
            if ($urandom_range(0, 2) != 0) begin
                if (t.f3[1:0] == 2'd1) t.addr[0] = 1'b0;
                else if (t.f3[1:0] == 2'd2) t.addr[1:0] = 2'b00;
            end
            run_txn(t);
            if (op == 9) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
